// File: rtl/n64a_vmux_if.sv
// Pixel offer/accept channel into the N64 VI-style video multiplexer.
// The master offers a packed pixel; the slave accepts it when valid and ready are both high.
interface n64a_vmux_if #(
    parameter int vdata_width_i = 25
);
    logic                     pix_valid_i;
    logic                     pix_ready_o;
    logic [vdata_width_i-1:0] pix_data_i;

    modport master (output pix_valid_i, output pix_data_i, input pix_ready_o);
    modport slave  (input pix_valid_i, input pix_data_i, output pix_ready_o);
endinterface

// File: rtl/n64a_vmux.sv
// N64 VI-style video multiplexer: serializes {sync, R, G, B} pixels onto nVDSYNC/VD_o, one pixel every 4 VCLK.
// Optional build macro N64A_VMUX_UFCNT_EN adds a saturating underflow counter (ufcnt_o, ufcnt_clr_i).
module n64a_vmux #(
    parameter int color_width_i = 7,
    parameter int vdata_width_i = 25
) (
    input  logic                     VCLK,
    input  logic                     nRST,
    input  logic                     en_i,
    input  logic                     n15bit_mode_i,
    input  logic                     blank_en_i,
    input  logic                     palmode_i,
    n64a_vmux_if.slave               pix,
    output logic                     nVDSYNC,
    output logic [color_width_i-1:0] VD_o,
    output logic                     underflow_o
`ifdef N64A_VMUX_UFCNT_EN
    ,
    input  logic                     ufcnt_clr_i,
    output logic [15:0]              ufcnt_o
`endif
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                   r_state;
    logic [1:0]               r_ph;
    logic [3:0]               r_sync;
    logic [color_width_i-1:0] r_r;
    logic [color_width_i-1:0] r_g;
    logic [color_width_i-1:0] r_b;
    logic                     r_nblank;
    logic                     r_nvdsync;
    logic [color_width_i-1:0] r_vd;
    logic                     r_underflow;

    logic                     w_load_slot;
    logic                     w_xfer;
    logic                     w_uf;
    logic                     w_blank;
    logic                     w_csync_rise;
    logic                     w_nblank_next;
    logic [3:0]               w_new_sync;
    logic [3:0]               w_load_sync;
    logic [color_width_i-1:0] w_new_r;
    logic [color_width_i-1:0] w_new_g;
    logic [color_width_i-1:0] w_new_b;

    // In 15-bit mode the two colour LSBs are zeroed on the bus.
    function automatic logic [color_width_i-1:0] f_mask15(
        input logic [color_width_i-1:0] c,
        input logic                     full
    );
        return full ? c : {c[color_width_i-1:2], 2'b00};
    endfunction

    function automatic logic [color_width_i-1:0] f_sync_word(input logic [3:0] s);
        return {{(color_width_i-4){1'b0}}, s};
    endfunction

    // Ready is combinational so a rising en_i in IDLE is visible the same cycle; held low in reset.
    assign w_load_slot     = en_i & ((r_state == IDLE) | (r_ph == 2'd3));
    assign pix.pix_ready_o = nRST & w_load_slot;
    assign w_xfer          = pix.pix_valid_i & pix.pix_ready_o;
    assign w_uf            = (r_state == RUN) & (r_ph == 2'd3) & en_i & ~pix.pix_valid_i;

    assign w_new_sync = pix.pix_data_i[vdata_width_i-1 -: 4];
    assign w_new_r    = f_mask15(pix.pix_data_i[3*color_width_i-1 -: color_width_i], n15bit_mode_i);
    assign w_new_g    = f_mask15(pix.pix_data_i[2*color_width_i-1 -: color_width_i], n15bit_mode_i);
    assign w_new_b    = f_mask15(pix.pix_data_i[color_width_i-1:0], n15bit_mode_i);

    // A starved repeat reuses the latched sync, so it can never produce an nCSYNC edge.
    assign w_load_sync   = w_xfer ? w_new_sync : r_sync;
    assign w_csync_rise  = w_load_sync[0] & ~r_sync[0];
    assign w_nblank_next = blank_en_i ? (w_csync_rise ? palmode_i : ~r_nblank) : 1'b1;
    assign w_blank       = blank_en_i & ~r_nblank;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge VCLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= IDLE;
            r_ph        <= 2'd0;
            r_sync      <= 4'd0;
            r_r         <= '0;
            r_g         <= '0;
            r_b         <= '0;
            r_nblank    <= 1'b1;
            r_nvdsync   <= 1'b1;
            r_vd        <= '0;
            r_underflow <= 1'b0;
        end else begin
            r_underflow <= 1'b0;
            if (!blank_en_i) begin
                r_nblank <= 1'b1;
            end
            unique case (r_state)
                IDLE: begin
                    r_nvdsync <= 1'b1;
                    r_vd      <= '0;
                    if (w_xfer) begin
                        r_state   <= RUN;
                        r_ph      <= 2'd0;
                        r_sync    <= w_new_sync;
                        r_r       <= w_new_r;
                        r_g       <= w_new_g;
                        r_b       <= w_new_b;
                        r_nblank  <= w_nblank_next;
                        r_nvdsync <= 1'b0;
                        r_vd      <= f_sync_word(w_new_sync);
                    end
                end
                RUN: begin
                    r_ph <= r_ph + 2'd1;
                    unique case (r_ph)
                        2'd0: begin
                            r_nvdsync <= 1'b1;
                            r_vd      <= w_blank ? '0 : r_r;
                        end
                        2'd1: begin
                            r_nvdsync <= 1'b1;
                            r_vd      <= w_blank ? '0 : r_g;
                        end
                        2'd2: begin
                            r_nvdsync <= 1'b1;
                            r_vd      <= w_blank ? '0 : r_b;
                        end
                        2'd3: begin
                            if (!en_i) begin
                                r_state   <= IDLE;
                                r_ph      <= 2'd0;
                                r_nvdsync <= 1'b1;
                                r_vd      <= '0;
                            end else begin
                                r_sync      <= w_load_sync;
                                r_r         <= w_xfer ? w_new_r : '0;
                                r_g         <= w_xfer ? w_new_g : '0;
                                r_b         <= w_xfer ? w_new_b : '0;
                                r_nblank    <= w_nblank_next;
                                r_nvdsync   <= 1'b0;
                                r_vd        <= f_sync_word(w_load_sync);
                                r_underflow <= w_uf;
                            end
                        end
                    endcase
                end
            endcase
        end
    end

    assign nVDSYNC     = r_nvdsync;
    assign VD_o        = r_vd;
    assign underflow_o = r_underflow;

`ifdef N64A_VMUX_UFCNT_EN
    logic [15:0] r_ufcnt;

    // Clear has priority over a coincident underflow.
    always_ff @(posedge VCLK or negedge nRST) begin
        if (!nRST) begin
            r_ufcnt <= 16'd0;
        end else if (ufcnt_clr_i) begin
            r_ufcnt <= 16'd0;
        end else if (w_uf && (r_ufcnt != 16'hFFFF)) begin
            r_ufcnt <= r_ufcnt + 16'd1;
        end
    end

    assign ufcnt_o = r_ufcnt;
`endif

endmodule
